// File: rtl/vc_alloc_ctl.sv
// Round-robin output-VC allocator with per-VC credit tracking. vc_sel registered one cycle after head valid.
// fl_rdy is low while idle or while the selected VC has no credit. Optional cr_err port via VC_CREDIT_ERR_EN.
module vc_alloc_ctl #(
  parameter int VCN        = 2,
  parameter int CW         = 3,
  parameter int CREDIT_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           fl_vld,
  input  logic           fl_tail,
  output logic           fl_rdy,
  output logic [VCN-1:0] vc_sel,
  input  logic [VCN-1:0] cr_ret,
  output logic [VCN-1:0] vc_cr_nz
`ifdef VC_CREDIT_ERR_EN
  ,
  output logic           cr_err
`endif
);

  localparam int PW = (VCN > 1) ? $clog2(VCN) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] rr_nxt;
  logic [PW:0]   cand;
  logic [VCN-1:0] pick;
  logic          found;
  logic          xfer;
  logic [VCN-1:0] xfer_vec;
  logic [CW-1:0] credit     [VCN];
  logic [CW-1:0] credit_nxt [VCN];

  assign fl_rdy   = (state == ACTIVE) && (|(vc_sel & vc_cr_nz));
  assign xfer     = fl_vld & fl_rdy;
  assign xfer_vec = xfer ? vc_sel : '0;

  // First VC with credit at or after the rr pointer, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < VCN; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(VCN)) cand = cand - (PW+1)'(VCN);
      if (!found && vc_cr_nz[cand[PW-1:0]]) begin
        pick[cand[PW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < VCN; i++) begin
      if (vc_sel[i]) sel_idx = PW'(i);
    end
  end

  assign rr_nxt = (sel_idx == PW'(VCN-1)) ? '0 : sel_idx + PW'(1);

  // A return arriving with a simultaneous transfer cancels out; returns at max are dropped.
  always_comb begin
    for (int i = 0; i < VCN; i++) begin
      credit_nxt[i] = credit[i];
      if (xfer_vec[i] && !cr_ret[i]) begin
        credit_nxt[i] = credit[i] - CW'(1);
      end else if (cr_ret[i] && !xfer_vec[i] && (credit[i] != CMAX)) begin
        credit_nxt[i] = credit[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vc_sel   <= '0;
      rr_ptr   <= '0;
      vc_cr_nz <= '1;
      for (int i = 0; i < VCN; i++) credit[i] <= CMAX;
    end else begin
      for (int i = 0; i < VCN; i++) begin
        credit[i]   <= credit_nxt[i];
        vc_cr_nz[i] <= (credit_nxt[i] != '0);
      end
      case (state)
        IDLE: begin
          if (fl_vld && found) begin
            vc_sel <= pick;
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (xfer && fl_tail) begin
            state  <= IDLE;
            vc_sel <= '0;
            rr_ptr <= rr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VC_CREDIT_ERR_EN
  logic [VCN-1:0] at_max;

  always_comb begin
    for (int i = 0; i < VCN; i++) at_max[i] = (credit[i] == CMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_err <= 1'b0;
    end else if (|(cr_ret & ~xfer_vec & at_max)) begin
      cr_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_alloc_ctl.sv
// Scoreboard bench for vc_alloc_ctl: integer reference model predicts per-cycle outputs, monitor compares.
module tb_vc_alloc_ctl;

  localparam int VCN  = 2;
  localparam int CW   = 3;
  localparam int CMAX = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           fl_vld;
  logic           fl_tail;
  logic           fl_rdy;
  logic [VCN-1:0] vc_sel;
  logic [VCN-1:0] cr_ret;
  logic [VCN-1:0] vc_cr_nz;
`ifdef VC_CREDIT_ERR_EN
  logic           cr_err;
`endif

  vc_alloc_ctl #(.VCN(VCN), .CW(CW), .CREDIT_MAX(CMAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fl_vld   (fl_vld),
    .fl_tail  (fl_tail),
    .fl_rdy   (fl_rdy),
    .vc_sel   (vc_sel),
    .cr_ret   (cr_ret),
    .vc_cr_nz (vc_cr_nz)
`ifdef VC_CREDIT_ERR_EN
    ,
    .cr_err   (cr_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VCN-1:0] sel;
    logic           rdy;
    logic [VCN-1:0] nz;
    logic           err;
  } snap_t;

  snap_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: credits as integers, current VC as an index (-1 = no packet open).
  int  cred [VCN];
  int  cur;
  int  rr;
  int  alloc;
  int  v;
  bit  mx;
  bit  m_err;
  snap_t s;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < VCN; i++) cred[i] = CMAX;
      cur   = -1;
      rr    = 0;
      m_err = 0;
      sb.delete();
    end else begin
      alloc = -1;
      mx    = (cur >= 0) && fl_vld && (cred[cur] > 0);
      if (cur < 0 && fl_vld) begin
        for (int k = 0; k < VCN; k++) begin
          v = (rr + k) % VCN;
          if (alloc < 0 && cred[v] > 0) alloc = v;
        end
      end
      for (int i = 0; i < VCN; i++) begin
        if (mx && cur == i && !cr_ret[i]) cred[i] = cred[i] - 1;
        else if (cr_ret[i] && !(mx && cur == i)) begin
          if (cred[i] == CMAX) m_err = 1;
          else cred[i] = cred[i] + 1;
        end
      end
      if (alloc >= 0) cur = alloc;
      else if (mx && fl_tail) begin
        rr  = (cur + 1) % VCN;
        cur = -1;
      end
      s = '0;
      if (cur >= 0) begin
        s.sel[cur] = 1'b1;
        s.rdy      = cred[cur] > 0;
      end
      for (int i = 0; i < VCN; i++) s.nz[i] = (cred[i] != 0);
      s.err = m_err;
      sb.push_back(s);
    end
  end

  snap_t e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual=0 expected=1 t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("vc_sel", 32'(vc_sel), 32'(e.sel));
        chk("fl_rdy", 32'(fl_rdy), 32'(e.rdy));
        chk("vc_cr_nz", 32'(vc_cr_nz), 32'(e.nz));
        chk("onehot", 32'($countones(vc_sel) <= 1), 32'd1);
`ifdef VC_CREDIT_ERR_EN
        chk("cr_err", 32'(cr_err), 32'(e.err));
`endif
      end
    end
  end

  task automatic drive(input logic vv, input logic tt, input logic [VCN-1:0] rr_in, input int n);
    repeat (n) begin
      @(negedge clk);
      fl_vld  = vv;
      fl_tail = tt;
      cr_ret  = rr_in;
    end
  endtask

  task automatic reset_checks();
    chk("rst_vc_sel", 32'(vc_sel), 32'd0);
    chk("rst_fl_rdy", 32'(fl_rdy), 32'd0);
    chk("rst_vc_cr_nz", 32'(vc_cr_nz), 32'((1 << VCN) - 1));
`ifdef VC_CREDIT_ERR_EN
    chk("rst_cr_err", 32'(cr_err), 32'd0);
`endif
  endtask

  // Asserts reset between edges, keeps it low across one rising edge, releases between edges.
  task automatic do_reset();
    @(negedge clk);
    fl_vld  = 1'b0;
    fl_tail = 1'b0;
    cr_ret  = '0;
    #2 rst_n = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    fl_vld  = 1'b0;
    fl_tail = 1'b0;
    cr_ret  = '0;
    repeat (2) @(negedge clk);
    reset_checks();
    #2 rst_n = 1'b1;

    // Single-flit packets alternate VC0, VC1, VC0.
    drive(1'b1, 1'b1, 2'b00, 6);
    drive(1'b0, 1'b0, 2'b00, 2);

    // 5-flit packet on VC0: stalls after four credits, one return releases it.
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 5);
    drive(1'b1, 1'b1, 2'b00, 3);
    drive(1'b1, 1'b1, 2'b01, 1);
    drive(1'b1, 1'b1, 2'b00, 2);
    // VC0 empty, next head goes to VC1 and drains it; then both empty until a return.
    drive(1'b1, 1'b0, 2'b00, 5);
    drive(1'b1, 1'b1, 2'b00, 2);
    drive(1'b1, 1'b1, 2'b00, 3);
    drive(1'b1, 1'b1, 2'b10, 1);
    drive(1'b1, 1'b1, 2'b00, 3);

    // Transfer with simultaneous return on the selected VC, then overflow return on VC1.
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 2);
    drive(1'b1, 1'b0, 2'b01, 2);
    drive(1'b1, 1'b1, 2'b10, 1);
    drive(1'b0, 1'b0, 2'b00, 3);

    // Reset mid-packet with VC0 at credit 2; next head must take VC0.
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 3);
    do_reset();
    drive(1'b1, 1'b1, 2'b00, 3);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fl_vld  = ($urandom % 4) != 0;
      fl_tail = ($urandom % 3) == 0;
      for (int i = 0; i < VCN; i++) cr_ret[i] = ($urandom % 4) == 0;
      if (($urandom % 400) == 0) do_reset();
    end
    drive(1'b0, 1'b0, 2'b00, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
